// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, return-address stack, two-word branch assembly, ret and trap.
// Optional RSTACK_TRAP_EN: return-stack overflow/underflow also halts the fetch stage.
module fetch_unit #(
  parameter int unsigned RSDEPTH = 4,
  parameter int unsigned RSPW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        jf_zero,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  output logic        halt,
  output logic        rs_ovf,
  output logic        rs_unf
);

  localparam logic [3:0]    OpCall  = 4'hC;
  localparam logic [3:0]    OpJump  = 4'hD;
  localparam logic [3:0]    OpJumpf = 4'hE;
  localparam logic [RSPW:0] CntFull = (RSPW + 1)'(RSDEPTH);

  typedef enum logic [1:0] {StRun, StAddr, StHalt} state_e;

  state_e          r_state, w_state_d;
  logic [15:0]     r_pc, w_pc_d;
  logic [15:0]     r_ir, w_ir_d;
  logic [15:0]     r_ir_pc, w_ir_pc_d;
  logic            r_ir_valid, w_ir_valid_d;
  logic            r_halt, w_halt_d;
  logic            r_ovf, w_ovf_d;
  logic            r_unf, w_unf_d;
  logic [3:0]      r_kind, w_kind_d;
  logic [7:0]      r_low, w_low_d;
  logic [RSPW:0]   r_cnt;
  logic [15:0]     r_stk [RSDEPTH];
  logic            w_push, w_pop;

  logic [3:0]      w_opcode;
  logic            w_is_br, w_is_ret, w_is_trap;
  logic            w_full, w_empty;
  logic [RSPW-1:0] w_top_idx, w_push_idx;
  logic [15:0]     w_top, w_pc_inc, w_target;

  assign w_opcode   = imem_data[15:12];
  assign w_is_br    = (w_opcode == OpCall) || (w_opcode == OpJump) || (w_opcode == OpJumpf);
  assign w_is_ret   = (w_opcode == 4'h0) && (imem_data[3:0] == 4'h1);
  assign w_is_trap  = (w_opcode == 4'h0) && (imem_data[3:0] == 4'h0);
  assign w_full     = (r_cnt == CntFull);
  assign w_empty    = (r_cnt == '0);
  assign w_top_idx  = RSPW'(r_cnt - 1'b1);
  assign w_push_idx = r_cnt[RSPW-1:0];
  assign w_top      = r_stk[w_top_idx];
  assign w_pc_inc   = r_pc + 16'd1;
  assign w_target   = {imem_data[7:0], r_low};

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_ir_d       = r_ir;
    w_ir_pc_d    = r_ir_pc;
    w_ir_valid_d = r_ir_valid;
    w_halt_d     = r_halt;
    w_ovf_d      = r_ovf;
    w_unf_d      = r_unf;
    w_kind_d     = r_kind;
    w_low_d      = r_low;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    if (!stall) begin
      case (r_state)
        StRun: begin
          w_ir_d       = imem_data;
          w_ir_pc_d    = r_pc;
          w_ir_valid_d = 1'b1;
          w_pc_d       = w_pc_inc;
          if (w_is_br) begin
            w_low_d   = imem_data[7:0];
            w_kind_d  = w_opcode;
            w_state_d = StAddr;
          end else if (w_is_ret) begin
            if (!w_empty) begin
              w_pc_d = w_top;
              w_pop  = 1'b1;
            end else begin
              w_unf_d = 1'b1;
`ifdef RSTACK_TRAP_EN
              w_halt_d  = 1'b1;
              w_pc_d    = r_pc;
              w_state_d = StHalt;
`endif
            end
          end else if (w_is_trap) begin
            w_halt_d  = 1'b1;
            w_pc_d    = r_pc;
            w_state_d = StHalt;
          end
        end
        StAddr: begin
          // The addr word is emitted for decode but never decoded here.
          w_ir_d       = imem_data;
          w_ir_pc_d    = r_pc;
          w_ir_valid_d = 1'b1;
          w_pc_d       = w_pc_inc;
          w_state_d    = StRun;
          case (r_kind)
            OpJump:  w_pc_d = w_target;
            OpJumpf: w_pc_d = jf_zero ? w_target : w_pc_inc;
            OpCall: begin
              w_pc_d = w_target;
              w_push = 1'b1;
              if (w_full) begin
                w_ovf_d = 1'b1;
`ifdef RSTACK_TRAP_EN
                w_halt_d  = 1'b1;
                w_state_d = StHalt;
`endif
              end
            end
            default: w_pc_d = w_pc_inc;
          endcase
        end
        StHalt:  w_ir_valid_d = 1'b0;
        default: w_state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StRun;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halt     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_kind     <= '0;
      r_low      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_ir       <= w_ir_d;
      r_ir_pc    <= w_ir_pc_d;
      r_ir_valid <= w_ir_valid_d;
      r_halt     <= w_halt_d;
      r_ovf      <= w_ovf_d;
      r_unf      <= w_unf_d;
      r_kind     <= w_kind_d;
      r_low      <= w_low_d;
    end
  end

  // A push onto a full stack shifts out the oldest entry and the count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < RSDEPTH; i++) r_stk[i] <= '0;
    end else if (w_push) begin
      if (w_full) begin
        for (int i = 0; i < RSDEPTH - 1; i++) r_stk[i] <= r_stk[i+1];
        r_stk[RSDEPTH-1] <= w_pc_inc;
      end else begin
        r_stk[w_push_idx] <= w_pc_inc;
        r_cnt             <= r_cnt + 1'b1;
      end
    end else if (w_pop) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;
  assign halt      = r_halt;
  assign rs_ovf    = r_ovf;
  assign rs_unf    = r_unf;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs push expected fetches, a monitor checks them.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        jf_zero;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        halt;
  logic        rs_ovf;
  logic        rs_unf;

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .stall     (stall),
    .jf_zero   (jf_zero),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .halt      (halt),
    .rs_ovf    (rs_ovf),
    .rs_unf    (rs_unf)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
    logic        ovf;
    logic        unf;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic stall_at_edge = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fill_default();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h5000 | 16'(i & 32'hFFF);
  endtask

  task automatic exp_w(input logic [15:0] pc, input logic ovf, input logic unf, input logic hlt);
    exp_t e;
    e.pc = pc; e.word = mem[pc]; e.ovf = ovf; e.unf = unf; e.hlt = hlt;
    q.push_back(e);
  endtask

  task automatic exp_seq(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) exp_w(16'(p), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (q.size() > 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    n_checks++;
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain_%s: %0d fetches never presented, required 0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset   = 1'b1;
    stall   = 1'b0;
    jf_zero = 1'b0;
    @(negedge clk);
    fill_default();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) stall_at_edge <= stall;

  // Each unstalled edge with ir_valid presents exactly one new fetch.
  always @(negedge clk) begin
    if (!reset && ir_valid && !stall_at_edge && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("ir_pc@%h", e.pc), 32'(ir_pc), 32'(e.pc));
      chk($sformatf("ir@%h", e.pc), 32'(ir), 32'(e.word));
      chk($sformatf("rs_ovf@%h", e.pc), 32'(rs_ovf), 32'(e.ovf));
      chk($sformatf("rs_unf@%h", e.pc), 32'(rs_unf), 32'(e.unf));
      chk($sformatf("halt@%h", e.pc), 32'(halt), 32'(e.hlt));
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int i;
    reset   = 1'b1;
    stall   = 1'b0;
    jf_zero = 1'b0;
    fill_default();
    repeat (2) @(negedge clk);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_ovf", 32'(rs_ovf), 32'd0);
    chk("rst_unf", 32'(rs_unf), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);

    // Sequential non-branch words.
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;
    mem[3] = 16'h4ABC; mem[4] = 16'h5DEF; mem[5] = 16'h6012;
    exp_seq(0, 5);
    release_reset();
    chk("valid_before_first_edge", 32'(ir_valid), 32'd0);
    drain("seq");

    // Unconditional jump with its addr word.
    hold_reset();
    mem[3] = 16'hD034; mem[4] = 16'hF012;
    exp_seq(0, 4);
    exp_w(16'h1234, 1'b0, 1'b0, 1'b0);
    exp_w(16'h1235, 1'b0, 1'b0, 1'b0);
    release_reset();
    drain("jump");

    // Call and return.
    hold_reset();
    mem[16'h10] = 16'hC020; mem[16'h11] = 16'hF001; mem[16'h120] = 16'h0001;
    exp_seq(0, 16'h11);
    exp_w(16'h0120, 1'b0, 1'b0, 1'b0);
    exp_w(16'h0012, 1'b0, 1'b0, 1'b0);
    exp_w(16'h0013, 1'b0, 1'b0, 1'b0);
    release_reset();
    drain("call_ret");

    // jumpf taken.
    hold_reset();
    mem[5] = 16'hE080; mem[6] = 16'hF000;
    jf_zero = 1'b1;
    exp_seq(0, 6);
    exp_w(16'h0080, 1'b0, 1'b0, 1'b0);
    exp_w(16'h0081, 1'b0, 1'b0, 1'b0);
    release_reset();
    drain("jumpf_taken");

    // jumpf not taken.
    hold_reset();
    mem[5] = 16'hE080; mem[6] = 16'hF000;
    exp_seq(0, 8);
    release_reset();
    drain("jumpf_fall");

    // jumpf with a 2-cycle stall in the addr slot; jf_zero counts only once unstalled.
    hold_reset();
    mem[5] = 16'hE080; mem[6] = 16'hF000;
    exp_seq(0, 6);
    exp_w(16'h0080, 1'b0, 1'b0, 1'b0);
    exp_w(16'h0081, 1'b0, 1'b0, 1'b0);
    release_reset();
    i = 0;
    while (imem_addr !== 16'd6 && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("reach_addr_slot", 32'(imem_addr), 32'd6);
    stall   = 1'b1;
    jf_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_pc_hold", 32'(imem_addr), 32'd6);
    chk("stall_ir_pc_hold", 32'(ir_pc), 32'd5);
    stall   = 1'b0;
    jf_zero = 1'b1;
    drain("jumpf_stall");

    // Five nested calls then five rets with a 4-deep stack.
    hold_reset();
    mem[16'h10] = 16'hC020; mem[16'h11] = 16'hF000;
    mem[16'h20] = 16'hC030; mem[16'h21] = 16'hF000;
    mem[16'h30] = 16'hC040; mem[16'h31] = 16'hF000;
    mem[16'h40] = 16'hC050; mem[16'h41] = 16'hF000;
    mem[16'h50] = 16'hC060; mem[16'h51] = 16'hF000;
    mem[16'h60] = 16'h0001; mem[16'h52] = 16'h0001; mem[16'h42] = 16'h0001;
    mem[16'h32] = 16'h0001; mem[16'h22] = 16'h0001;
    exp_seq(0, 16'h11);
    exp_seq(16'h20, 16'h21); exp_seq(16'h30, 16'h31); exp_seq(16'h40, 16'h41);
    exp_w(16'h50, 1'b0, 1'b0, 1'b0);
`ifdef RSTACK_TRAP_EN
    exp_w(16'h51, 1'b1, 1'b0, 1'b1);
    release_reset();
    drain("nest_trap");
    repeat (3) @(negedge clk);
    chk("nest_trap_halt", 32'(halt), 32'd1);
    chk("nest_trap_valid", 32'(ir_valid), 32'd0);
`else
    exp_w(16'h51, 1'b1, 1'b0, 1'b0);
    exp_w(16'h60, 1'b1, 1'b0, 1'b0);
    exp_w(16'h52, 1'b1, 1'b0, 1'b0);
    exp_w(16'h42, 1'b1, 1'b0, 1'b0);
    exp_w(16'h32, 1'b1, 1'b0, 1'b0);
    exp_w(16'h22, 1'b1, 1'b1, 1'b0);
    exp_w(16'h23, 1'b1, 1'b1, 1'b0);
    exp_w(16'h24, 1'b1, 1'b1, 1'b0);
    release_reset();
    drain("nest");
`endif

    // Trap, then an asynchronous reset pulse.
    hold_reset();
    mem[8] = 16'h0000;
    exp_seq(0, 7);
    exp_w(16'h8, 1'b0, 1'b0, 1'b1);
    release_reset();
    drain("trap");
    repeat (3) @(negedge clk);
    chk("trap_valid_low", 32'(ir_valid), 32'd0);
    chk("trap_halt", 32'(halt), 32'd1);
    chk("trap_ir_pc", 32'(ir_pc), 32'd8);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_halt", 32'(halt), 32'd0);
    chk("async_rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("async_rst_pc", 32'(imem_addr), 32'd0);
    exp_seq(0, 2);
    release_reset();
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
